// File: rtl/pacman_pkg.sv
// Shared sprite geometry, colour constants and the rgb_t pixel type for the maze renderer.
package pacman_pkg;
  typedef logic [23:0] rgb_t;

  localparam int   SPRITE_W     = 26;
  localparam int   SPRITE_H     = 26;
  localparam rgb_t KEY_COLOR    = 24'h000000;
  localparam rgb_t FRIGHT_COLOR = 24'h2121FF;
  localparam rgb_t FLASH_COLOR  = 24'hFFFFFF;
endpackage

// File: rtl/frame_counter.sv
// 4-bit frame counter advancing once per tick, wrapping 15 -> 0.
// Single-cycle update; no backpressure.
module frame_counter (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       tick,
  output logic [3:0] count
);
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)    count <= '0;
    else if (tick) count <= count + 4'd1;
  end
endmodule

// File: rtl/ghost_sprite_reader.sv
// Ghost sprite lookup: hit test and RAM address, then key/frightened colouring.
// Fixed 2-cycle latency, one pixel per cycle, never stalls.
module ghost_sprite_reader #(
  parameter int               SPRITE_W     = pacman_pkg::SPRITE_W,
  parameter int               SPRITE_H     = pacman_pkg::SPRITE_H,
  parameter pacman_pkg::rgb_t KEY_COLOR    = pacman_pkg::KEY_COLOR,
  parameter pacman_pkg::rgb_t FRIGHT_COLOR = pacman_pkg::FRIGHT_COLOR,
  parameter pacman_pkg::rgb_t FLASH_COLOR  = pacman_pkg::FLASH_COLOR
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic [9:0]  GhostX,
  input  logic [9:0]  GhostY,
  input  logic        face_left,
  input  logic        frightened,
  input  logic        flash,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        pix_valid,
  output logic [9:0]  read_address,
  input  logic [23:0] ram_data,
  output logic        out_valid,
  output logic        sprite_on,
  output logic [23:0] sprite_color
);
  import pacman_pkg::*;

  logic [9:0] sh_x, sh_y;
  logic       sh_left, sh_fright, sh_flash;
  logic [3:0] frame_cnt;

  // Shadows only move at vblank so a frame is drawn from one consistent snapshot.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sh_x      <= '0;
      sh_y      <= '0;
      sh_left   <= 1'b0;
      sh_fright <= 1'b0;
      sh_flash  <= 1'b0;
    end else if (frame_tick) begin
      sh_x      <= GhostX;
      sh_y      <= GhostY;
      sh_left   <= face_left;
      sh_fright <= frightened;
      sh_flash  <= flash;
    end
  end

  frame_counter u_frame_counter (
    .Clk   (Clk),
    .Reset (Reset),
    .tick  (frame_tick),
    .count (frame_cnt)
  );

  logic [10:0] x_lo, x_hi, y_lo, y_hi;
  logic        hit;
  logic [9:0]  dx, dy, col, addr;

  // 11-bit bounds keep sprites parked near 1023 from wrapping back to column 0.
  assign x_lo = {1'b0, sh_x};
  assign y_lo = {1'b0, sh_y};
  assign x_hi = x_lo + 11'(SPRITE_W - 1);
  assign y_hi = y_lo + 11'(SPRITE_H - 1);
  assign hit  = pix_valid
             && ({1'b0, DrawX} >= x_lo) && ({1'b0, DrawX} <= x_hi)
             && ({1'b0, DrawY} >= y_lo) && ({1'b0, DrawY} <= y_hi);

  assign dx   = DrawX - sh_x;
  assign dy   = DrawY - sh_y;
  assign col  = sh_left ? (10'(SPRITE_W - 1) - dx) : dx;
  assign addr = dy * 10'(SPRITE_W) + col;
  assign read_address = hit ? addr : '0;

  logic s1_vld, s1_hit, s1_fright, s1_flash_on;

  // Mode bits travel with the pixel so a tick mid-flight cannot recolour it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1_vld      <= 1'b0;
      s1_hit      <= 1'b0;
      s1_fright   <= 1'b0;
      s1_flash_on <= 1'b0;
    end else begin
      s1_vld      <= pix_valid;
      s1_hit      <= hit;
      s1_fright   <= sh_fright;
      s1_flash_on <= sh_flash & frame_cnt[3];
    end
  end

  logic px_on;
  rgb_t px_color;

  always_comb begin
    px_on    = s1_hit && (ram_data != KEY_COLOR);
    px_color = '0;
    if (px_on) begin
      if (!s1_fright)      px_color = ram_data;
      else if (s1_flash_on) px_color = FLASH_COLOR;
      else                 px_color = FRIGHT_COLOR;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      out_valid    <= 1'b0;
      sprite_on    <= 1'b0;
      sprite_color <= '0;
    end else begin
      out_valid    <= s1_vld;
      sprite_on    <= px_on;
      sprite_color <= px_color;
    end
  end
endmodule
